// File: rtl/soc_uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte streams, with message locking.
// Optional lock-release timeout is enabled by defining SOC_UART_TX_SCHED_TIMEOUT_EN.
module soc_uart_tx_sched #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    uclk,
    input  logic                    res,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    uart_start_tx,
    output logic [7:0]              uart_tx_data,
    input  logic                    uart_tx_empty,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    locked,
    output logic                    busy
);

    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("soc_uart_tx_sched: unsupported parameter value");
    end

    typedef enum logic [1:0] {ARB, LAUNCH, WAIT_DONE} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] ready_n;
    logic            start_n;
    logic [7:0]      data_n;
    logic [GW-1:0]   gid_n;
    logic            locked_n;
    logic            busy_n;

    logic            win;
    logic [GW-1:0]   win_idx;
    logic [7:0]      win_data;
    logic            win_last;
    int              base;

`ifdef SOC_UART_TX_SCHED_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt, to_cnt_n;
`endif

    // Rotating priority search starting after the last grantee; a lock narrows it to the grantee alone.
    always_comb begin
        win      = 1'b0;
        win_idx  = '0;
        win_data = '0;
        win_last = 1'b0;
        base     = int'(grant_id);
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win && req_valid[i] && (i == (base + k) % NREQ) && (!locked || i == base)) begin
                    win      = 1'b1;
                    win_idx  = GW'(i);
                    win_data = req_data[8*i +: 8];
                    win_last = req_last[i];
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        ready_n  = '0;
        start_n  = uart_start_tx;
        data_n   = uart_tx_data;
        gid_n    = grant_id;
        locked_n = locked;
        unique case (state)
            ARB: begin
                if (win) begin
                    data_n           = win_data;
                    ready_n[win_idx] = 1'b1;
                    gid_n            = win_idx;
                    locked_n         = ~win_last;
                    start_n          = 1'b1;
                    state_n          = LAUNCH;
                end
            end
            // start_tx is held because the UART ignores it during its stop bit while still reporting empty.
            LAUNCH: begin
                if (!uart_tx_empty) begin
                    start_n = 1'b0;
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (uart_tx_empty) begin
                    state_n = ARB;
                end
            end
            default: state_n = ARB;
        endcase
`ifdef SOC_UART_TX_SCHED_TIMEOUT_EN
        to_cnt_n = to_cnt;
        if (!locked || (state == ARB && win)) begin
            to_cnt_n = '0;
        end else if (state == ARB && !req_valid[grant_id]) begin
            if (to_cnt == TO_LAST) begin
                to_cnt_n = '0;
                locked_n = 1'b0;
            end else begin
                to_cnt_n = to_cnt + TW'(1);
            end
        end
`endif
        busy_n = (state_n != ARB);
    end

    always_ff @(posedge uclk) begin
        if (res) begin
            state         <= ARB;
            req_ready     <= '0;
            uart_start_tx <= 1'b0;
            uart_tx_data  <= '0;
            grant_id      <= GW'(NREQ - 1);
            locked        <= 1'b0;
            busy          <= 1'b0;
`ifdef SOC_UART_TX_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            state         <= state_n;
            req_ready     <= ready_n;
            uart_start_tx <= start_n;
            uart_tx_data  <= data_n;
            grant_id      <= gid_n;
            locked        <= locked_n;
            busy          <= busy_n;
`ifdef SOC_UART_TX_SCHED_TIMEOUT_EN
            to_cnt        <= to_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_soc_uart_tx_sched.sv
// Self-checking bench for soc_uart_tx_sched: UART model + line receiver, message-level round-robin reference.
module tb_soc_uart_tx_sched;

    localparam int NREQ   = 4;
    localparam int TO_CYC = 16;
    localparam int DIV    = 4;

    logic              uclk;
    logic              res;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              uart_start_tx;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_empty;
    logic [1:0]        grant_id;
    logic              locked;
    logic              busy;

    soc_uart_tx_sched #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .uclk(uclk), .res(res), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .uart_start_tx(uart_start_tx), .uart_tx_data(uart_tx_data),
        .uart_tx_empty(uart_tx_empty), .grant_id(grant_id), .locked(locked), .busy(busy)
    );

    initial begin
        uclk = 1'b0;
        forever #5 uclk = ~uclk;
    end

    // UART transmitter model: 0 idle, 1 start, 2 data, 3 stop; reports empty in idle and stop, accepts only in idle.
    int         uart_phase = 0;
    int         uart_tick = 0;
    int         uart_nbit = 0;
    int         uart_accepts = 0;
    logic [7:0] uart_sh = '0;
    logic       uart_line = 1'b1;
    assign uart_tx_empty = (uart_phase == 0) || (uart_phase == 3);

    always @(posedge uclk) begin
        if (res) begin
            uart_phase <= 0;
            uart_tick  <= 0;
            uart_line  <= 1'b1;
        end else begin
            case (uart_phase)
                0: if (uart_start_tx) begin
                    uart_sh      <= uart_tx_data;
                    uart_phase   <= 1;
                    uart_tick    <= 0;
                    uart_line    <= 1'b0;
                    uart_accepts <= uart_accepts + 1;
                end
                1: if (uart_tick == DIV - 1) begin
                    uart_tick  <= 0;
                    uart_phase <= 2;
                    uart_nbit  <= 0;
                    uart_line  <= uart_sh[0];
                end else uart_tick <= uart_tick + 1;
                2: if (uart_tick == DIV - 1) begin
                    uart_tick <= 0;
                    if (uart_nbit == 7) begin
                        uart_phase <= 3;
                        uart_line  <= 1'b1;
                    end else begin
                        uart_nbit <= uart_nbit + 1;
                        uart_sh   <= uart_sh >> 1;
                        uart_line <= uart_sh[1];
                    end
                end else uart_tick <= uart_tick + 1;
                default: if (uart_tick == DIV - 1) begin
                    uart_tick  <= 0;
                    uart_phase <= 0;
                end else uart_tick <= uart_tick + 1;
            endcase
        end
    end

    logic [7:0] rx_q[$];
    int         stop_err = 0;

    // Line receiver: decodes start, 8 data bits LSB first, stop.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_line);
            repeat (DIV / 2) @(negedge uclk);
            for (int k = 0; k < 8; k++) begin
                repeat (DIV) @(negedge uclk);
                b[k] = uart_line;
            end
            repeat (DIV) @(negedge uclk);
            if (uart_line !== 1'b1) stop_err++;
            rx_q.push_back(b);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] pend_data [NREQ][32];
    logic       pend_last [NREQ][32];
    int         pend_cnt [NREQ];
    int         pend_ptr [NREQ];
    int         acc_id[$];
    logic       acc_lock[$];
    logic [7:0] exp_byte[$];
    int         exp_id[$];
    logic       exp_lock[$];
    int         model_gid;
    int         checks = 0;
    int         failures = 0;
    int         onehot_err = 0;
    int         drop_err = 0;
    bit         seen_start_in_stop;
    logic       prev_start = 1'b0;
    int         prev_phase = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic addByte(input int r, input logic [7:0] d, input logic l);
        pend_data[r][pend_cnt[r]] = d;
        pend_last[r][pend_cnt[r]] = l;
        pend_cnt[r]++;
    endtask

    task automatic clearLogs();
        rx_q.delete(); acc_id.delete(); acc_lock.delete();
        exp_byte.delete(); exp_id.delete(); exp_lock.delete();
    endtask

    task automatic expectByte(input logic [7:0] d, input int id, input logic lk);
        exp_byte.push_back(d); exp_id.push_back(id); exp_lock.push_back(lk);
    endtask

    // One cycle of requester behaviour: retire accepted bytes, present the next pending byte.
    task automatic cycleService();
        @(negedge uclk);
        if ($countones(req_ready) > 1) onehot_err++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                acc_id.push_back(i);
                acc_lock.push_back(locked);
                pend_ptr[i]++;
            end
        end
        if (uart_phase == 3 && uart_start_tx) seen_start_in_stop = 1'b1;
        if (prev_start && !uart_start_tx && prev_phase != 1 && !res) drop_err++;
        prev_start = uart_start_tx;
        prev_phase = uart_phase;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_ptr[i] < pend_cnt[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = pend_data[i][pend_ptr[i]];
                req_last[i]        = pend_last[i][pend_ptr[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int max_cycles, output bit done);
        bit all;
        done = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            cycleService();
            all = 1'b1;
            for (int i = 0; i < NREQ; i++) if (pend_ptr[i] < pend_cnt[i]) all = 1'b0;
            if (all && !busy && uart_phase == 0 && req_ready == '0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic doReset();
        res = 1'b1;
        req_valid = '0;
        req_last = '0;
        for (int i = 0; i < NREQ; i++) begin pend_cnt[i] = 0; pend_ptr[i] = 0; end
        repeat (2) @(negedge uclk);
        res = 1'b0;
        prev_start = 1'b0;
        model_gid = NREQ - 1;
        clearLogs();
    endtask

    // Reference: message-granular round robin over requesters that still hold messages.
    task automatic modelRun();
        int  mptr [NREQ];
        int  w;
        bit  l;
        exp_byte.delete(); exp_id.delete(); exp_lock.delete();
        for (int i = 0; i < NREQ; i++) mptr[i] = pend_ptr[i];
        forever begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (model_gid + k) % NREQ;
                if (w < 0 && mptr[c] < pend_cnt[c]) w = c;
            end
            if (w < 0) break;
            model_gid = w;
            do begin
                l = pend_last[w][mptr[w]];
                expectByte(pend_data[w][mptr[w]], w, !l);
                mptr[w]++;
            end while (!l && mptr[w] < pend_cnt[w]);
        end
    endtask

    task automatic compareRun(input string tag);
        checkOutput({tag, "_nbytes"}, rx_q.size(), exp_byte.size());
        checkOutput({tag, "_naccept"}, acc_id.size(), exp_id.size());
        for (int j = 0; j < exp_byte.size() && j < rx_q.size(); j++)
            checkOutput($sformatf("%s_byte%0d", tag, j), rx_q[j], exp_byte[j]);
        for (int j = 0; j < exp_id.size() && j < acc_id.size(); j++) begin
            checkOutput($sformatf("%s_id%0d", tag, j), acc_id[j], exp_id[j]);
            checkOutput($sformatf("%s_lock%0d", tag, j), acc_lock[j], exp_lock[j]);
        end
    endtask

    initial begin
        bit done;
        int n;
        int acc0;
        int nm, len;
        res = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NREQ; i++) begin pend_cnt[i] = 0; pend_ptr[i] = 0; end
        repeat (3) @(negedge uclk);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_start", uart_start_tx, 0);
        checkOutput("rst_data", uart_tx_data, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gid", grant_id, NREQ - 1);
        res = 1'b0;
        model_gid = NREQ - 1;
        clearLogs();

        $display("[TB] single requester");
        acc0 = uart_accepts;
        addByte(0, 8'h55, 1'b1);
        expectByte(8'h55, 0, 1'b0);
        applyStimulus(300, done);
        checkOutput("single_done", done, 1);
        compareRun("single");
        checkOutput("single_uart_accepts", uart_accepts - acc0, 1);
        checkOutput("single_locked", locked, 0);

        $display("[TB] fairness");
        doReset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NREQ; i++) addByte(i, 8'hA0 + 8'(i), 1'b1);
        modelRun();
        applyStimulus(1000, done);
        checkOutput("fair_done", done, 1);
        compareRun("fair");
        checkOutput("fair_gid", grant_id, model_gid);

        $display("[TB] message lock");
        clearLogs();
        addByte(1, 8'h11, 1'b0);
        addByte(1, 8'h12, 1'b0);
        addByte(1, 8'h13, 1'b1);
        addByte(2, 8'h2A, 1'b1);
        modelRun();
        applyStimulus(1000, done);
        checkOutput("lock_done", done, 1);
        compareRun("lock");
        checkOutput("lock_gid", grant_id, model_gid);

        $display("[TB] stop-bit hazard and withdrawn request");
        clearLogs();
        seen_start_in_stop = 1'b0;
        acc0 = uart_accepts;
        addByte(3, 8'h3C, 1'b1);
        n = 0;
        while (acc_id.size() == 0 && n < 200) begin cycleService(); n++; end
        checkOutput("hazard_wait_accept", acc_id.size(), 1);
        addByte(1, 8'hEE, 1'b1);
        cycleService();
        cycleService();
        pend_cnt[1] = pend_ptr[1];
        n = 0;
        while (uart_phase != 3 && n < 200) begin cycleService(); n++; end
        checkOutput("hazard_wait_stop", uart_phase, 3);
        addByte(0, 8'h5A, 1'b1);
        applyStimulus(300, done);
        expectByte(8'h3C, 3, 1'b0);
        expectByte(8'h5A, 0, 1'b0);
        checkOutput("hazard_done", done, 1);
        compareRun("hazard");
        checkOutput("hazard_start_in_stop", seen_start_in_stop, 1);
        checkOutput("hazard_uart_accepts", uart_accepts - acc0, 2);

        $display("[TB] reset mid-transfer");
        clearLogs();
        addByte(2, 8'h77, 1'b1);
        n = 0;
        while (!(busy && !uart_start_tx && acc_id.size() > 0) && n < 200) begin cycleService(); n++; end
        checkOutput("rstmid_wait_waitdone", busy && !uart_start_tx, 1);
        res = 1'b1;
        @(negedge uclk);
        res = 1'b0;
        checkOutput("rstmid_ready", req_ready, 0);
        checkOutput("rstmid_start", uart_start_tx, 0);
        checkOutput("rstmid_data", uart_tx_data, 0);
        checkOutput("rstmid_locked", locked, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_gid", grant_id, NREQ - 1);
        repeat (14 * DIV) cycleService();
        clearLogs();
        addByte(0, 8'h42, 1'b1);
        expectByte(8'h42, 0, 1'b0);
        applyStimulus(300, done);
        checkOutput("rstmid_done", done, 1);
        compareRun("rstmid");

        $display("[TB] randomized messages");
        doReset();
        for (int i = 0; i < NREQ; i++) begin
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) begin
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) addByte(i, 8'($urandom), b == len - 1);
            end
        end
        modelRun();
        applyStimulus(4000, done);
        checkOutput("rand_done", done, 1);
        compareRun("rand");
        checkOutput("rand_gid", grant_id, model_gid);

        $display("[TB] abandoned lock");
        doReset();
        addByte(3, 8'h30, 1'b0);
        n = 0;
        while (acc_id.size() == 0 && n < 200) begin cycleService(); n++; end
        checkOutput("timeout_wait_accept", acc_id.size(), 1);
        addByte(0, 8'h0F, 1'b1);
        applyStimulus(400, done);
        expectByte(8'h30, 3, 1'b1);
`ifdef SOC_UART_TX_SCHED_TIMEOUT_EN
        expectByte(8'h0F, 0, 1'b0);
        checkOutput("timeout_done", done, 1);
        checkOutput("timeout_locked", locked, 0);
`else
        checkOutput("timeout_done", done, 0);
        checkOutput("timeout_locked", locked, 1);
`endif
        compareRun("timeout");

        checkOutput("onehot_ready", onehot_err, 0);
        checkOutput("stop_bits", stop_err, 0);
        checkOutput("start_held", drop_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
